// File: rtl/feed_msg_decoder.sv
// Market-data message decoder: validates fixed 10-byte ADD messages from a byte stream
// and emits {price, quantity} beats with a side flag; counts good and dropped messages.
module feed_msg_decoder #(
    parameter int unsigned MSG_BYTES = 10,
    parameter logic [7:0]  TYPE_ADD  = 8'h41,
    parameter logic [7:0]  SIDE_BID  = 8'h42,
    parameter logic [7:0]  SIDE_ASK  = 8'h53
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic [63:0] m_tdata,
    output logic        m_tside,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [31:0] msg_count,
    output logic [15:0] err_count
);

    localparam logic [3:0] LAST_IDX = 4'(MSG_BYTES - 1);

    typedef enum logic [1:0] {
        HDR,
        BODY,
        DROP
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  idx, idx_nxt;
    logic [55:0] asm_data;
    logic        asm_side;
    logic        accept;
    logic        err;
    logic        load;
    logic        side_bad;

    // Only the final byte can stall, and only when the holding register cannot drain.
    assign s_tready = !((state == BODY) && (idx == LAST_IDX) && m_tvalid && !m_tready);
    assign accept   = s_tvalid && s_tready;
    assign side_bad = (s_tdata != SIDE_BID) && (s_tdata != SIDE_ASK);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        err       = 1'b0;
        load      = 1'b0;
        if (accept) begin
            case (state)
                HDR: begin
                    if (s_tdata != TYPE_ADD) begin
                        err = 1'b1;
                        if (!s_tlast) state_nxt = DROP;
                    end else if (s_tlast) begin
                        err = 1'b1;
                    end else begin
                        state_nxt = BODY;
                        idx_nxt   = 4'd1;
                    end
                end
                BODY: begin
                    // Any error leaves BODY, so a message reaching the last byte is clean.
                    if (idx == 4'd1 && side_bad) begin
                        err       = 1'b1;
                        state_nxt = s_tlast ? HDR : DROP;
                        idx_nxt   = '0;
                    end else if (idx == LAST_IDX) begin
                        if (s_tlast) begin
                            load      = 1'b1;
                            state_nxt = HDR;
                        end else begin
                            err       = 1'b1;
                            state_nxt = DROP;
                        end
                        idx_nxt = '0;
                    end else if (s_tlast) begin
                        err       = 1'b1;
                        state_nxt = HDR;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end
                DROP: begin
                    if (s_tlast) state_nxt = HDR;
                end
                default: begin
                    state_nxt = HDR;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HDR;
            idx       <= '0;
            asm_data  <= '0;
            asm_side  <= 1'b0;
            m_tdata   <= '0;
            m_tside   <= 1'b0;
            m_tvalid  <= 1'b0;
            msg_count <= '0;
            err_count <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (accept && state == BODY && idx != LAST_IDX) begin
                if (idx == 4'd1) asm_side <= (s_tdata == SIDE_BID);
                else             asm_data <= {asm_data[47:0], s_tdata};
            end
            if (load) begin
                m_tdata   <= {asm_data, s_tdata};
                m_tside   <= asm_side;
                m_tvalid  <= 1'b1;
                msg_count <= msg_count + 32'd1;
            end else if (m_tvalid && m_tready) begin
                m_tvalid <= 1'b0;
            end
            if (err && err_count != '1) err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_feed_msg_decoder.sv
// Directed bench for feed_msg_decoder: framing errors, back-pressure, reset mid-message.
module tb_feed_msg_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic        m_tside;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] msg_count;
    logic [15:0] err_count;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    feed_msg_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tside   (m_tside),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .msg_count (msg_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one byte and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [7:0] d, input logic l);
        bit ok = 1'b0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            mismatched++;
            $error("FAIL send_timeout: observed s_tready stuck 0 expected 1");
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Sends the first nbytes of a message; tlast is set on byte position last_pos.
    task automatic send_msg(input logic [7:0] t, input logic [7:0] s,
                            input logic [31:0] p, input logic [31:0] q,
                            input int nbytes, input int last_pos);
        logic [7:0] b [10];
        b[0] = t;
        b[1] = s;
        for (int k = 0; k < 4; k++) begin
            b[2 + k] = p[31 - 8 * k -: 8];
            b[6 + k] = q[31 - 8 * k -: 8];
        end
        for (int i = 0; i < nbytes; i++) send(b[i], i == last_pos);
    endtask

    initial begin
        rst      = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", 64'(s_tready), 64'd1);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tdata", m_tdata, 64'd0);
        chk("rst_m_tside", 64'(m_tside), 64'd0);
        chk("rst_msg_count", 64'(msg_count), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Good bid
        send_msg(8'h41, 8'h42, 32'h64, 32'h0A, 10, 9);
        chk("bid_valid", 64'(m_tvalid), 64'd1);
        chk("bid_data", m_tdata, 64'h00000064_0000000A);
        chk("bid_side", 64'(m_tside), 64'd1);
        chk("bid_msg_count", 64'(msg_count), 64'd1);
        chk("bid_err_count", 64'(err_count), 64'd0);
        @(posedge clk);
        #1 chk("bid_drained", 64'(m_tvalid), 64'd0);

        // Two asks under back-pressure
        m_tready = 1'b0;
        send_msg(8'h41, 8'h53, 32'h65, 32'h1, 10, 9);
        chk("ask1_valid", 64'(m_tvalid), 64'd1);
        chk("ask1_data", m_tdata, 64'h00000065_00000001);
        chk("ask1_side", 64'(m_tside), 64'd0);
        send_msg(8'h41, 8'h53, 32'h63, 32'h2, 9, 99);
        s_tdata  = 8'h02;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        repeat (5) @(negedge clk);
        chk("stall_s_tready", 64'(s_tready), 64'd0);
        chk("stall_hold_data", m_tdata, 64'h00000065_00000001);
        chk("stall_hold_valid", 64'(m_tvalid), 64'd1);
        chk("stall_msg_count", 64'(msg_count), 64'd2);
        m_tready = 1'b1;
        #1 chk("unstall_s_tready", 64'(s_tready), 64'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk("ask2_valid", 64'(m_tvalid), 64'd1);
        chk("ask2_data", m_tdata, 64'h00000063_00000002);
        chk("ask2_msg_count", 64'(msg_count), 64'd3);
        @(posedge clk);
        #1 chk("ask2_drained", 64'(m_tvalid), 64'd0);

        // Bad type, then a good message
        send_msg(8'h58, 8'h42, 32'h11, 32'h22, 1, 99);
        chk("badtype_err_now", 64'(err_count), 64'd1);
        send_msg(8'h58, 8'h42, 32'h11, 32'h22, 10, 9);
        send_msg(8'h58, 8'h42, 32'h11, 32'h22, 0, 99);
        chk("badtype_err", 64'(err_count), 64'd1);
        chk("badtype_no_beat", 64'(msg_count), 64'd3);
        send_msg(8'h41, 8'h42, 32'h1234, 32'h5678, 10, 9);
        chk("after_badtype_data", m_tdata, 64'h00001234_00005678);
        chk("after_badtype_count", 64'(msg_count), 64'd4);

        // Early tlast on byte 4
        send_msg(8'h41, 8'h42, 32'h99, 32'h99, 4, 3);
        chk("early_err", 64'(err_count), 64'd2);
        send_msg(8'h41, 8'h53, 32'hDEADBEEF, 32'h01020304, 10, 9);
        chk("after_early_data", m_tdata, 64'hDEADBEEF_01020304);
        chk("after_early_side", 64'(m_tside), 64'd0);
        chk("after_early_count", 64'(msg_count), 64'd5);

        // Missing tlast on byte 10; tlast on byte 13
        send_msg(8'h41, 8'h42, 32'h7, 32'h8, 10, 99);
        chk("missing_err", 64'(err_count), 64'd3);
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        send(8'h00, 1'b1);
        chk("missing_no_beat", 64'(msg_count), 64'd5);
        chk("missing_err_once", 64'(err_count), 64'd3);
        send_msg(8'h41, 8'h42, 32'hA0, 32'hB0, 10, 9);
        chk("after_missing_data", m_tdata, 64'h000000A0_000000B0);
        chk("after_missing_count", 64'(msg_count), 64'd6);

        // Bad side with tlast
        send_msg(8'h41, 8'h99, 32'h0, 32'h0, 2, 1);
        chk("badside_err", 64'(err_count), 64'd4);

        // Reset after byte 5, then a zero-price, zero-quantity bid
        send_msg(8'h41, 8'h42, 32'h55, 32'h66, 5, 99);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_s_tready", 64'(s_tready), 64'd1);
        chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("midrst_m_tdata", m_tdata, 64'd0);
        chk("midrst_msg_count", 64'(msg_count), 64'd0);
        chk("midrst_err_count", 64'(err_count), 64'd0);
        rst = 1'b0;
        send_msg(8'h41, 8'h42, 32'h0, 32'h0, 10, 9);
        chk("zero_valid", 64'(m_tvalid), 64'd1);
        chk("zero_data", m_tdata, 64'd0);
        chk("zero_side", 64'(m_tside), 64'd1);
        chk("zero_msg_count", 64'(msg_count), 64'd1);
        chk("zero_err_count", 64'(err_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/feed_msg_decoder.md
# feed_msg_decoder

Upstream front end of the order book. It takes a byte-wide AXI-Stream of fixed-format market-data messages and checks each message's framing, type and side. Each good message becomes one 64-bit beat, {price[31:0], quantity[31:0]}, plus a side flag, on an AXI-Stream master that feeds the book's slave port. Malformed messages are dropped and counted; good ones are counted.

## Interface
- MSG_BYTES, 10: bytes per message; fixed. Byte 0 = type, byte 1 = side, bytes 2-5 = price big-endian, bytes 6-9 = quantity big-endian.
- TYPE_ADD, 8'h41: only accepted message type.
- SIDE_BID, 8'h42 / SIDE_ASK, 8'h53: legal side codes.
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- s_tdata, input, 8: message byte.
- s_tvalid, input, 1: byte valid.
- s_tlast, input, 1: last byte of message.
- s_tready, output, 1: byte accepted when s_tvalid && s_tready.
- m_tdata, output, 64: {price, quantity}.
- m_tside, output, 1: 1 = bid, 0 = ask; qualified by m_tvalid.
- m_tvalid, output, 1: decoded message available.
- m_tready, input, 1: downstream accepts beat.
- msg_count, output, 32: good messages emitted; wraps at 2^32.
- err_count, output, 16: dropped messages; saturates at 16'hFFFF.

## Operation
- States:
  - HDR: expects byte 0.
  - BODY: bytes 1-9; a 4-bit idx holds the byte position.
  - DROP: discards bytes until tlast.
- HDR, byte accepted:
  - Type != TYPE_ADD: error. With tlast, stay in HDR; otherwise go to DROP.
  - Type OK with tlast: error (early tlast); stay in HDR.
  - Type OK, no tlast: idx=1, go to BODY.
- BODY, byte at idx=1: side must be 8'h42 or 8'h53, else error.
- BODY, bytes 2-9: shift into the assembly register, price MSB first, then quantity MSB first.
- BODY, tlast on idx<9: error (early tlast); return to HDR.
- BODY, idx=9 without tlast: error (missing tlast); go to DROP.
- BODY, idx=9 with tlast and no earlier error: load the output register, set m_tvalid, increment msg_count, return to HDR.
- Bad side at idx=1:
  - Without tlast: go to DROP.
  - With tlast: counts as one error; return to HDR.
- DROP: discards every byte; returns to HDR on the accepted byte with tlast.
- Each malformed message increments err_count exactly once, at the cycle its first error is detected.
- Decoding is purely structural: no price or quantity range checks. Price 0 and quantity 0 are forwarded unchanged.
- Output holding register is a single entry:
  - Cleared by m_tvalid && m_tready.
  - m_tdata and m_tside stay stable while m_tvalid && !m_tready.
- s_tready:
  - Low only when state=BODY, idx=9, m_tvalid=1 and m_tready=0.
  - Otherwise high, including in HDR and DROP.
  - Bytes 0-8 are never stalled.
- Reset mid-message: any partial message is discarded without counting. The next accepted byte is treated as byte 0.

## Timing
- Reset values:
  - s_tready=1, m_tvalid=0, m_tdata=0, m_tside=0.
  - msg_count=0, err_count=0.
  - State HDR, idx=0.
- Latency: m_tvalid rises on the clock edge that accepts byte 9.
  - The beat is visible the cycle after that byte's handshake.
  - msg_count updates on the same edge.
- Throughput: one message per 10 cycles with s_tvalid and m_tready held high. Output is never blocked in that case.
- Simultaneous drain and load (m_tvalid && m_tready while byte 9 is accepted): the new beat replaces the old one; m_tvalid stays 1.
- s_tready is combinational from m_tvalid, m_tready, state and idx. There is no combinational path from s_tvalid to m_tvalid.
- Counter updates are registered and visible the cycle after the triggering handshake.

## Test plan
- Good bid (41 42 00 00 00 64 00 00 00 0A, tlast on byte 10), m_tready=1 -> one beat, m_tdata=64'h00000064_0000000A, m_tside=1, msg_count=1, err_count=0.
- Two back-to-back asks, prices 0x65 then 0x63, m_tready=0 until 5 cycles after the second message's byte 9 is presented -> s_tready low on that byte; first beat held stable; then both beats delivered in order; msg_count=2.
- Bad type 0x58 in a 10-byte message, followed by a good message -> err_count=1; only the good message is emitted.
- Early tlast on byte 4, then a good message -> err_count=1; good message decoded correctly.
- Missing tlast on byte 10, tlast on byte 13, then a good message -> bytes 11-13 dropped; err_count=1, msg_count=1.
- rst asserted after byte 5 of a message, then a good message -> no beat and no count for the partial message; good message decoded; all outputs at reset values during rst.
